// File: rtl/ramio.sv
`default_nettype none
// ============================================================================
// Module   : ramio
// Purpose  : CPU load/store front end for the cache plus LED / UART I/O window.
// Revision : 1.0 - initial release
// ============================================================================
module ramio #(
    parameter int          RAM_ADDRESS_BIT_WIDTH = 21,
    parameter logic [31:0] ADDRESS_LED           = 32'hFFFF_FFFF,
    parameter logic [31:0] ADDRESS_UART_OUT      = 32'hFFFF_FFFE,
    parameter logic [31:0] ADDRESS_UART_IN       = 32'hFFFF_FFFD
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        enable,
    input  logic [31:0] address,
    input  logic [1:0]  write_type,
    input  logic [2:0]  read_type,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_ready,
    output logic        busy,
    output logic        error,

    output logic        cache_enable,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    input  logic        cache_busy,

    output logic [5:0]  led,

    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_go,
    input  logic        uart_tx_bsy,

    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_dr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_t;

    localparam logic [1:0] c_wt_byte = 2'd1;
    localparam logic [1:0] c_wt_half = 2'd2;
    localparam logic [1:0] c_wt_word = 2'd3;
    localparam logic [2:0] c_rt_lb   = 3'd1;
    localparam logic [2:0] c_rt_lh   = 3'd2;
    localparam logic [2:0] c_rt_lw   = 3'd3;
    localparam logic [2:0] c_rt_lbu  = 3'd5;
    localparam logic [2:0] c_rt_lhu  = 3'd6;

    tx_state_t   r_tx_state;
    logic [7:0]  r_rx_data;
    logic        r_rx_full;

    logic        w_is_rd;
    logic        w_is_wr;
    logic        w_bad_type;
    logic        w_size_byte;
    logic        w_size_half;
    logic        w_size_word;
    logic        w_misaligned;
    logic        w_hit_led;
    logic        w_hit_out;
    logic        w_hit_in;
    logic        w_hit_io;
    logic        w_in_ram;
    logic        w_hit_ram;
    logic        w_active;
    logic        w_illegal;
    logic        w_ok;
    logic        w_ram_ok;
    logic        w_led_wr;
    logic        w_led_rd;
    logic        w_in_rd;
    logic        w_out_wr;
    logic        w_tx_accept;
    logic [15:0] w_lane;
    logic [31:0] w_load;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_rd      = (read_type != 3'd0);
        w_is_wr      = (write_type != 2'd0);
        w_bad_type   = (read_type == 3'd4) || (read_type == 3'd7) || (w_is_rd && w_is_wr);
        w_size_byte  = (write_type == c_wt_byte) || (read_type == c_rt_lb) || (read_type == c_rt_lbu);
        w_size_half  = (write_type == c_wt_half) || (read_type == c_rt_lh) || (read_type == c_rt_lhu);
        w_size_word  = (write_type == c_wt_word) || (read_type == c_rt_lw);
        w_misaligned = (w_size_half && address[0]) || (w_size_word && (address[1:0] != 2'b00));

        w_hit_led    = (address == ADDRESS_LED);
        w_hit_out    = (address == ADDRESS_UART_OUT);
        w_hit_in     = (address == ADDRESS_UART_IN);
        w_hit_io     = w_hit_led || w_hit_out || w_hit_in;
        w_in_ram     = ((address >> (RAM_ADDRESS_BIT_WIDTH + 2)) == 32'd0);
        // I/O decode takes precedence should a window ever overlap RAM.
        w_hit_ram    = w_in_ram && !w_hit_io;

        w_active     = enable && (w_is_rd || w_is_wr);
        w_illegal    = w_active && (w_bad_type || w_misaligned
                                    || (!w_hit_ram && !w_hit_io)
                                    || (w_hit_io && !w_size_byte)
                                    || (w_hit_out && w_is_rd)
                                    || (w_hit_in && w_is_wr));
        w_ok         = w_active && !w_illegal;

        w_ram_ok     = w_ok && w_hit_ram;
        w_led_wr     = w_ok && w_hit_led && w_is_wr;
        w_led_rd     = w_ok && w_hit_led && w_is_rd;
        w_in_rd      = w_ok && w_hit_in;
        w_out_wr     = w_ok && w_hit_out;
        w_tx_accept  = w_out_wr && (r_tx_state == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    always_comb begin
        cache_enable       = w_ram_ok;
        cache_address      = {address[31:2], 2'b00};
        cache_data_in      = data_in;
        cache_write_enable = 4'b0000;
        if (w_ram_ok && w_is_wr) begin
            case (write_type)
                c_wt_byte: begin
                    cache_write_enable = 4'b0001 << address[1:0];
                    cache_data_in      = {4{data_in[7:0]}};
                end
                c_wt_half: begin
                    cache_write_enable = 4'b0011 << address[1:0];
                    cache_data_in      = {2{data_in[15:0]}};
                end
                default: begin
                    cache_write_enable = 4'b1111;
                    cache_data_in      = data_in;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (address[1:0])
            2'd0:    w_lane = cache_data_out[15:0];
            2'd1:    w_lane = cache_data_out[23:8];
            2'd2:    w_lane = cache_data_out[31:16];
            default: w_lane = {8'h00, cache_data_out[31:24]};
        endcase

        case (read_type)
            c_rt_lb:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            c_rt_lh:  w_load = {{16{w_lane[15]}}, w_lane};
            c_rt_lw:  w_load = cache_data_out;
            c_rt_lbu: w_load = {24'h000000, w_lane[7:0]};
            c_rt_lhu: w_load = {16'h0000, w_lane};
            default:  w_load = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // CPU-side response
    // ------------------------------------------------------------------
    always_comb begin
        data_out       = 32'h0000_0000;
        data_out_ready = 1'b0;
        busy           = 1'b0;
        if (w_ram_ok) begin
            busy = cache_busy;
            if (w_is_rd) begin
                data_out       = w_load;
                data_out_ready = cache_data_out_ready;
            end
        end else if (w_led_rd) begin
            data_out       = {26'h0000000, led};
            data_out_ready = 1'b1;
        end else if (w_in_rd) begin
            data_out       = {24'h000000, (r_rx_full ? r_rx_data : 8'h00)};
            data_out_ready = 1'b1;
        end else if (w_out_wr) begin
            // TX writes stall only while a previous byte is still in flight.
            busy = (r_tx_state != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // LED register and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led   <= 6'h00;
            error <= 1'b0;
        end else begin
            if (w_led_wr) begin
                led <= data_in[5:0];
            end
            if (w_illegal) begin
                error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART RX holding register; a new strobe wins over a read-clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rx_full <= 1'b0;
        end else if (uart_rx_dr) begin
            r_rx_data <= uart_rx_data;
            r_rx_full <= 1'b1;
        end else if (w_in_rd) begin
            r_rx_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // UART TX handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state   <= ST_IDLE;
            uart_tx_data <= 8'h00;
            uart_tx_go   <= 1'b0;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_accept) begin
                        uart_tx_data <= data_in[7:0];
                        uart_tx_go   <= 1'b1;
                        r_tx_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_tx_bsy) begin
                        uart_tx_go <= 1'b0;
                        r_tx_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!uart_tx_bsy) begin
                        r_tx_state <= ST_IDLE;
                    end
                end
                default: begin
                    uart_tx_go <= 1'b0;
                    r_tx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ramio.sv
`default_nettype none
// ============================================================================
// Module   : tb_ramio
// Purpose  : Directed self-checking bench for ramio with a zero-latency cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ramio;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        error;
    logic        cache_enable;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;
    logic [31:0] cache_data_out;
    logic        cache_data_out_ready;
    logic        cache_busy;
    logic [5:0]  led;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_go;
    logic        uart_tx_bsy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_dr;

    int n_pass  = 0;
    int n_total = 0;

    ramio dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .address              (address),
        .write_type           (write_type),
        .read_type            (read_type),
        .data_in              (data_in),
        .data_out             (data_out),
        .data_out_ready       (data_out_ready),
        .busy                 (busy),
        .error                (error),
        .cache_enable         (cache_enable),
        .cache_address        (cache_address),
        .cache_data_in        (cache_data_in),
        .cache_write_enable   (cache_write_enable),
        .cache_data_out       (cache_data_out),
        .cache_data_out_ready (cache_data_out_ready),
        .cache_busy           (cache_busy),
        .led                  (led),
        .uart_tx_data         (uart_tx_data),
        .uart_tx_go           (uart_tx_go),
        .uart_tx_bsy          (uart_tx_bsy),
        .uart_rx_data         (uart_rx_data),
        .uart_rx_dr           (uart_rx_dr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency word memory standing in for the cache.
    logic [31:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    assign cache_data_out       = mem[cache_address[7:2]];
    assign cache_data_out_ready = cache_enable && (cache_write_enable == 4'b0000);
    always @(posedge clk) begin
        if (cache_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (cache_write_enable[b]) mem[cache_address[7:2]][8*b +: 8] <= cache_data_in[8*b +: 8];
            end
        end
    end

    // UART transmitter model: busy for 4 cycles starting the cycle after it sees go.
    int bsy_cnt = 0;
    initial uart_tx_bsy = 1'b0;
    always @(posedge clk) begin
        if (bsy_cnt == 0) begin
            if (uart_tx_go && !uart_tx_bsy) begin
                uart_tx_bsy <= 1'b1;
                bsy_cnt     <= 4;
            end
        end else begin
            bsy_cnt <= bsy_cnt - 1;
            if (bsy_cnt == 1) uart_tx_bsy <= 1'b0;
        end
    end

    int   go_rises = 0;
    logic prev_go  = 1'b0;
    always @(posedge clk) begin
        prev_go <= uart_tx_go;
        if (uart_tx_go && !prev_go) go_rises <= go_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic en, input logic [31:0] a, input logic [1:0] wt,
                         input logic [2:0] rt, input logic [31:0] d);
        enable     = en;
        address    = a;
        write_type = wt;
        read_type  = rt;
        data_in    = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int held;

    initial begin
        rst          = 1'b1;
        cache_busy   = 1'b0;
        uart_rx_data = 8'h00;
        uart_rx_dr   = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);

        @(negedge clk);
        chk("rst_led", {26'h0, led}, 32'h0);
        chk("rst_tx_data", {24'h0, uart_tx_data}, 32'h0);
        chk("rst_tx_go", {31'h0, uart_tx_go}, 32'h0);
        chk("rst_error", {31'h0, error}, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Word store then sub-word loads
        drive(1'b1, 32'h10, 2'd3, 3'd0, 32'h8001_5678);
        @(negedge clk);
        chk("sw_cache_enable", {31'h0, cache_enable}, 32'h1);
        chk("sw_cwe", {28'h0, cache_write_enable}, 32'hF);
        chk("sw_cache_addr", cache_address, 32'h10);
        chk("sw_busy", {31'h0, busy}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h12, 2'd0, 3'd2, 32'h0);
        @(negedge clk);
        chk("lh_0x12", data_out, 32'hFFFF_8001);
        chk("lh_ready", {31'h0, data_out_ready}, 32'h1);
        chk("lh_cwe", {28'h0, cache_write_enable}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h12, 2'd0, 3'd6, 32'h0);
        @(negedge clk);
        chk("lhu_0x12", data_out, 32'h0000_8001);
        next_cycle();
        drive(1'b1, 32'h10, 2'd0, 3'd1, 32'h0);
        @(negedge clk);
        chk("lb_0x10", data_out, 32'h0000_0078);
        next_cycle();

        // Byte store into lane 1
        drive(1'b1, 32'h21, 2'd1, 3'd0, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_cwe", {28'h0, cache_write_enable}, 32'h2);
        chk("sb_lane", {24'h0, cache_data_in[15:8]}, 32'hAB);
        chk("sb_cache_addr", cache_address, 32'h20);
        next_cycle();
        drive(1'b1, 32'h21, 2'd0, 3'd5, 32'h0);
        @(negedge clk);
        chk("lbu_0x21", data_out, 32'h0000_00AB);
        next_cycle();

        // Cache stall passes straight through
        cache_busy = 1'b1;
        drive(1'b1, 32'h10, 2'd0, 3'd3, 32'h0);
        @(negedge clk);
        chk("ram_busy", {31'h0, busy}, 32'h1);
        chk("lw_0x10", data_out, 32'h8001_5678);
        next_cycle();
        cache_busy = 1'b0;

        // LED write and read-back
        drive(1'b1, 32'hFFFF_FFFF, 2'd1, 3'd0, 32'h0000_0015);
        @(negedge clk);
        chk("led_wr_busy", {31'h0, busy}, 32'h0);
        chk("led_wr_cache_en", {31'h0, cache_enable}, 32'h0);
        next_cycle();
        drive(1'b1, 32'hFFFF_FFFF, 2'd0, 3'd5, 32'h0);
        @(negedge clk);
        chk("led_value", {26'h0, led}, 32'h15);
        chk("led_rd", data_out, 32'h0000_0015);
        chk("led_rd_ready", {31'h0, data_out_ready}, 32'h1);
        chk("led_rd_busy", {31'h0, busy}, 32'h0);
        next_cycle();

        // Back-to-back UART transmits
        drive(1'b1, 32'hFFFF_FFFE, 2'd1, 3'd0, 32'h41);
        @(negedge clk);
        chk("tx1_busy", {31'h0, busy}, 32'h0);
        next_cycle();
        drive(1'b1, 32'hFFFF_FFFE, 2'd1, 3'd0, 32'h42);
        @(negedge clk);
        chk("tx1_go", {31'h0, uart_tx_go}, 32'h1);
        chk("tx1_data", {24'h0, uart_tx_data}, 32'h41);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            if (!busy) break;
            held++;
            @(posedge clk);
            #1;
        end
        chk("tx2_held_cycles", held, 32'd6);
        next_cycle();
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        @(negedge clk);
        chk("tx2_data", {24'h0, uart_tx_data}, 32'h42);
        chk("tx2_go", {31'h0, uart_tx_go}, 32'h1);
        repeat (12) next_cycle();
        chk("tx_go_count", go_rises, 32'd2);
        chk("tx_go_idle", {31'h0, uart_tx_go}, 32'h0);

        // UART receive holding register
        uart_rx_data = 8'h5A;
        uart_rx_dr   = 1'b1;
        next_cycle();
        uart_rx_dr = 1'b0;
        drive(1'b1, 32'hFFFF_FFFD, 2'd0, 3'd5, 32'h0);
        @(negedge clk);
        chk("rx_read1", data_out, 32'h0000_005A);
        chk("rx_ready", {31'h0, data_out_ready}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("rx_read_empty", data_out, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        uart_rx_data = 8'h11;
        uart_rx_dr   = 1'b1;
        next_cycle();
        uart_rx_data = 8'h33;
        drive(1'b1, 32'hFFFF_FFFD, 2'd0, 3'd5, 32'h0);
        @(negedge clk);
        chk("rx_collide_old", data_out, 32'h0000_0011);
        next_cycle();
        uart_rx_dr = 1'b0;
        @(negedge clk);
        chk("rx_collide_new", data_out, 32'h0000_0033);
        next_cycle();

        // Misaligned word load
        drive(1'b1, 32'h06, 2'd0, 3'd3, 32'h0);
        @(negedge clk);
        chk("mis_cache_en", {31'h0, cache_enable}, 32'h0);
        chk("mis_busy", {31'h0, busy}, 32'h0);
        chk("mis_ready", {31'h0, data_out_ready}, 32'h0);
        chk("mis_err_before", {31'h0, error}, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        @(negedge clk);
        chk("mis_err_after", {31'h0, error}, 32'h1);

        // Unmapped byte store is dropped
        drive(1'b1, 32'h0100_0000, 2'd1, 3'd0, 32'hFF);
        @(negedge clk);
        chk("unmapped_cache_en", {31'h0, cache_enable}, 32'h0);
        next_cycle();

        // Reset while the TX FSM sits in Wait
        drive(1'b1, 32'hFFFF_FFFE, 2'd1, 3'd0, 32'h55);
        next_cycle();
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("wait_go_low", {31'h0, uart_tx_go}, 32'h0);
        chk("wait_bsy_high", {31'h0, uart_tx_bsy}, 32'h1);
        drive(1'b1, 32'hFFFF_FFFE, 2'd1, 3'd0, 32'h66);
        #1;
        chk("wait_pending_busy", {31'h0, busy}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_led", {26'h0, led}, 32'h0);
        chk("mid_rst_tx_data", {24'h0, uart_tx_data}, 32'h0);
        chk("mid_rst_tx_go", {31'h0, uart_tx_go}, 32'h0);
        chk("mid_rst_error", {31'h0, error}, 32'h0);
        chk("mid_rst_idle_busy", {31'h0, busy}, 32'h0);
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 32'hFFFF_FFFD, 2'd0, 3'd5, 32'h0);
        @(negedge clk);
        chk("post_rst_rx_empty", data_out, 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 2'd0, 3'd0, 32'h0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ramio.md
# ramio

CPU-facing memory front end that sits directly upstream of the `cache` in the SDRAM path. It translates RISC-V byte/half/word loads and stores into the cache's word-wide `address`/`data_in`/`write_enable` port, and shifts plus sign- or zero-extends returned words. It also decodes a small memory-mapped I/O window: LEDs, UART TX and UART RX. Misaligned or unmapped accesses are detected, dropped and reported.

## Interface
- `RamAddressBitWidth`, default 21: word-address width of cache/SDRAM; RAM region is byte addresses 0 .. 2^(RamAddressBitWidth+2)-1.
- `AddressLed`, default 32'hFFFF_FFFF: LED register, byte access only.
- `AddressUartOut`, default 32'hFFFF_FFFE: UART TX byte, write only.
- `AddressUartIn`, default 32'hFFFF_FFFD: UART RX byte, read only; read clears.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: CPU access request, held until `busy` low.
- `address` in 32: byte address.
- `write_type` in 2: 0 none, 1 byte, 2 half, 3 word.
- `read_type` in 3: 0 none, 1 lb, 2 lh, 3 lw, 5 lbu, 6 lhu.
- `data_in` in 32: store data, right-aligned.
- `data_out` out 32: load result, extended.
- `data_out_ready` out 1: `data_out` valid this cycle.
- `busy` out 1: request not yet complete; CPU holds all inputs.
- `error` out 1: sticky misaligned/unmapped/illegal-access flag.
- `cache_enable` out 1, `cache_address` out 32, `cache_data_in` out 32, `cache_write_enable` out 4: to cache.
- `cache_data_out` in 32, `cache_data_out_ready` in 1, `cache_busy` in 1: from cache.
- `led` out 6: LED register.
- `uart_tx_data` out 8, `uart_tx_go` out 1, `uart_tx_bsy` in 1: to UART transmitter.
- `uart_rx_data` in 8, `uart_rx_dr` in 1: one-cycle data-ready strobe from UART receiver.

## Operation
- Decode is combinational on `enable`, `address`, `read_type` and `write_type`. Targets: RAM, LED, UartOut, UartIn, or illegal.
- **RAM path (combinational pass-through):**
  - `cache_address = {address[31:2], 2'b00}`.
  - `cache_enable` = `enable` and legal RAM access.
  - `busy = cache_busy`.
  - `data_out_ready = cache_data_out_ready` on reads.
- **Stores, little-endian lanes:**
  - byte: `cache_write_enable = 4'b0001 << address[1:0]`; data replicated/shifted into that lane.
  - half: `4'b0011 << address[1:0]`.
  - word: `4'b1111`.
- **Loads:** select the byte/half at `address[1:0]` from `cache_data_out`. Sign-extend for lb/lh, zero-extend for lbu/lhu.
- **Misaligned:** half with `address[0]=1`, or word with `address[1:0]!=0`.
- **Illegal:** misaligned, or address outside the RAM region and not an I/O address, or non-byte access to I/O, or read of UartOut, or write of UartIn.
  - Effect: `error` set on next edge; access dropped (`cache_enable=0`, `busy=0`, `data_out_ready=0`).
- **LED:**
  - write: `led <= data_in[5:0]`.
  - read: `{26'b0, led}`, ready same cycle, `busy=0`.
- **UART RX:**
  - 8-bit holding register plus `rx_full`. `uart_rx_dr` loads it and sets `rx_full`.
  - Read of UartIn returns the byte if `rx_full`, else 0, ready same cycle. `rx_full` clears on that edge.
  - Read coinciding with `uart_rx_dr`: reader gets the old byte; the new byte is loaded and `rx_full` stays 1.
  - Overrun overwrites.
- **UART TX FSM:**
  - Idle: write to UartOut latches `uart_tx_data`, sets `uart_tx_go`, goes to Send. `busy=0` for this write.
  - Send: hold `uart_tx_go` until `uart_tx_bsy`=1, then clear go and go to Wait.
  - Wait: on `uart_tx_bsy`=0, go to Idle.
  - Write to UartOut while not in Idle: `busy=1` until Idle, then accepted as above.

## Timing
- Reset values: `led=0`, `uart_tx_data=0`, `uart_tx_go=0`, `error=0`, `rx_full=0`, FSM=Idle.
- Cache-side outputs are combinational; no added latency on RAM accesses.
- I/O reads: 0-cycle latency (`data_out_ready=1` while `enable` high).
- I/O writes: complete on the edge where `enable` is high and `busy` is low.
- `uart_tx_go` asserts the cycle after the accepting edge.
- Minimum TX turnaround is 3 edges when `uart_tx_bsy` responds in 1 cycle.
- `rst` mid-Send/Wait: immediate return to Idle with go=0; a pending CPU write is dropped.
- `error` clears only on `rst`.

## Test plan
- Store word 0x8001_5678 at 0x10, lh 0x12 -> `data_out`=0xFFFF_8001; lhu 0x12 -> 0x0000_8001; lb 0x10 -> 0x0000_0078.
- Store byte 0xAB at 0x21 -> `cache_write_enable`=4'b0010, `cache_data_in[15:8]`=0xAB; lbu 0x21 -> 0x0000_00AB.
- Write 0x15 to `AddressLed` -> `led`=6'h15 next cycle; read back -> 0x0000_0015 with `busy`=0.
- Two back-to-back UART writes 0x41, 0x42, with `uart_tx_bsy` high 4 cycles after go:
  - second write held with `busy`=1 until FSM is Idle;
  - `uart_tx_data`=0x42 afterwards;
  - `uart_tx_go` asserts exactly twice.
- `uart_rx_dr` with 0x5A, then read UartIn -> 0x5A; read again -> 0. Read on the same cycle as a new strobe with 0x33 -> old byte returned, next read returns 0x33.
- Misaligned lw 0x06 -> `cache_enable`=0, `error`=1 after the edge. Assert `rst` mid-Wait -> all outputs return to reset values.
